// File: rtl/pec_fifo_pkg.sv
// Shared types and sizes for the PEC 8 x 242 FIFO controller slice.
// The optional PEC_FIFO_ARB_STATS_EN build uses the stats width and the saturating helper.
package pec_fifo_pkg;

    localparam int unsigned PEC_FIFO_W      = 242;
    localparam int unsigned PEC_FIFO_DEPTH  = 8;
    localparam int unsigned PEC_FIFO_STAT_W = 16;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } pecFifoState_e;

    // Saturating increment for the statistics counters.
    function automatic logic [PEC_FIFO_STAT_W-1:0] satInc(input logic [PEC_FIFO_STAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pec_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after iRrPtr wins.
module pec_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = $clog2(NREQ)
) (
    input  logic            iEn,
    input  logic [NREQ-1:0] iReqVld,
    input  logic [PW-1:0]   iRrPtr,
    output logic [NREQ-1:0] oGnt,
    output logic [PW-1:0]   oGntIdx,
    output logic            oGntVld
);

    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        oGnt    = '0;
        oGntIdx = '0;
        oGntVld = 1'b0;
        found   = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = PW'((32'(iRrPtr) + k) % NREQ);
            if (iEn && !found && iReqVld[idx]) begin
                found     = 1'b1;
                oGnt[idx] = 1'b1;
                oGntIdx   = idx;
                oGntVld   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pec_fifo_wr_arb.sv
// Round-robin write arbiter, valid/ready read sequencer and flush controller for the PEC FIFO.
// Optional statistics outputs are built when PEC_FIFO_ARB_STATS_EN is defined.
module pec_fifo_wr_arb
    import pec_fifo_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned W     = PEC_FIFO_W,
    parameter int unsigned DEPTH = PEC_FIFO_DEPTH,
    parameter int unsigned LW    = $clog2(DEPTH + 1)
) (
    input  logic              iClk,
    input  logic              iRstn,
    input  logic [NREQ-1:0]   iReqVld,
    input  logic [NREQ*W-1:0] iReqData,
    output logic [NREQ-1:0]   oReqGnt,
    output logic              oFifoWe,
    output logic [W-1:0]      oFifoWData,
    output logic              oFifoRe,
    input  logic [W-1:0]      iFifoRData,
    output logic              oRdVld,
    input  logic              iRdRdy,
    output logic [W-1:0]      oRdData,
    input  logic              iFlush,
    output logic              oFlushDone,
    output logic [LW-1:0]     oLevel,
    output logic              oBusy
`ifdef PEC_FIFO_ARB_STATS_EN
    ,
    output logic [PEC_FIFO_STAT_W-1:0]      oStallCnt,
    output logic [NREQ*PEC_FIFO_STAT_W-1:0] oGntCnt
`endif
);

    localparam int unsigned PW = $clog2(NREQ);

    pecFifoState_e state, stateNxt;
    logic [LW-1:0] level, levelNxt;
    logic [PW-1:0] rrPtr;
    logic          space;
    logic          gntEn;
    logic          gntVld;
    logic [PW-1:0] gntIdx;
    logic [NREQ-1:0] gnt;
    logic          flushDone;
    logic          busy;

    // A same-cycle pop is deliberately not credited toward space.
    assign space = (level < LW'(DEPTH));

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state <= ST_RUN;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        gntEn    = 1'b0;
        oRdVld   = 1'b0;
        oFifoRe  = 1'b0;
        unique case (state)
            ST_RUN: begin
                // Reset also masks grants so every output is quiet while iRstn is low.
                gntEn   = iRstn && space;
                oRdVld  = (level != '0);
                oFifoRe = oRdVld && iRdRdy;
                if (iFlush) stateNxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                oFifoRe = (level != '0);
                if (level == '0) stateNxt = ST_DONE;
            end
            ST_DONE: begin
                stateNxt = ST_RUN;
            end
            default: begin
                stateNxt = ST_RUN;
            end
        endcase
    end

    pec_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) uRrPick (
        .iEn     (gntEn),
        .iReqVld (iReqVld),
        .iRrPtr  (rrPtr),
        .oGnt    (gnt),
        .oGntIdx (gntIdx),
        .oGntVld (gntVld)
    );

    assign oReqGnt = gnt;
    assign oFifoWe = gntVld;
    assign oRdData = iFifoRData;

    // Mux the granted requester's slice onto the FIFO write port.
    always_comb begin
        oFifoWData = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) oFifoWData = oFifoWData | iReqData[i*W +: W];
        end
    end

    assign levelNxt = level + LW'(gntVld) - LW'(oFifoRe);

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            level     <= '0;
            rrPtr     <= '0;
            flushDone <= 1'b0;
            busy      <= 1'b0;
        end else begin
            level     <= levelNxt;
            flushDone <= (stateNxt == ST_DONE);
            busy      <= (stateNxt != ST_RUN);
            if (gntVld) begin
                rrPtr <= (gntIdx == PW'(NREQ - 1)) ? '0 : gntIdx + 1'b1;
            end
        end
    end

    assign oLevel     = level;
    assign oFlushDone = flushDone;
    assign oBusy      = busy;

`ifdef PEC_FIFO_ARB_STATS_EN
    logic statClr;
    logic [PEC_FIFO_STAT_W-1:0] stallCnt;

    assign statClr = (state == ST_RUN) && iFlush;

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            stallCnt <= '0;
        end else if (statClr) begin
            stallCnt <= '0;
        end else if ((state == ST_RUN) && (|iReqVld) && !space) begin
            stallCnt <= satInc(stallCnt);
        end
    end

    assign oStallCnt = stallCnt;

    for (genvar gi = 0; gi < NREQ; gi++) begin : gGntCnt
        logic [PEC_FIFO_STAT_W-1:0] cnt;
        always_ff @(posedge iClk or negedge iRstn) begin
            if (!iRstn) begin
                cnt <= '0;
            end else if (statClr) begin
                cnt <= '0;
            end else if (gnt[gi]) begin
                cnt <= satInc(cnt);
            end
        end
        assign oGntCnt[gi*PEC_FIFO_STAT_W +: PEC_FIFO_STAT_W] = cnt;
    end
`endif

    aLevelBound: assert property (@(posedge iClk) disable iff (!iRstn) level <= LW'(DEPTH));
    aNoUnderflow: assert property (@(posedge iClk) disable iff (!iRstn) !(oFifoRe && level == '0));
    aNoOverflow: assert property (@(posedge iClk) disable iff (!iRstn) !(oFifoWe && !oFifoRe && level == LW'(DEPTH)));

endmodule

// File: tb/tb_pec_fifo_wr_arb.sv
// Randomized bench for pec_fifo_wr_arb against a queue-based FIFO/arbiter reference model.
module tb_pec_fifo_wr_arb;
    import pec_fifo_pkg::*;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned W     = PEC_FIFO_W;
    localparam int unsigned DEPTH = PEC_FIFO_DEPTH;
    localparam int unsigned LW    = $clog2(DEPTH + 1);

    logic              iClk;
    logic              iRstn;
    logic [NREQ-1:0]   iReqVld;
    logic [NREQ*W-1:0] iReqData;
    logic [NREQ-1:0]   oReqGnt;
    logic              oFifoWe;
    logic [W-1:0]      oFifoWData;
    logic              oFifoRe;
    logic [W-1:0]      iFifoRData;
    logic              oRdVld;
    logic              iRdRdy;
    logic [W-1:0]      oRdData;
    logic              iFlush;
    logic              oFlushDone;
    logic [LW-1:0]     oLevel;
    logic              oBusy;

    pec_fifo_wr_arb #(.NREQ(NREQ)) dut (
        .iClk       (iClk),
        .iRstn      (iRstn),
        .iReqVld    (iReqVld),
        .iReqData   (iReqData),
        .oReqGnt    (oReqGnt),
        .oFifoWe    (oFifoWe),
        .oFifoWData (oFifoWData),
        .oFifoRe    (oFifoRe),
        .iFifoRData (iFifoRData),
        .oRdVld     (oRdVld),
        .iRdRdy     (iRdRdy),
        .oRdData    (oRdData),
        .iFlush     (iFlush),
        .oFlushDone (oFlushDone),
        .oLevel     (oLevel),
        .oBusy      (oBusy)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO contents, round-robin pointer, mode (0 run, 1 flush, 2 done).
    logic [W-1:0] q[$];
    int           mPtr;
    int           mState;
    logic [W-1:0] reqData [NREQ];
    logic [NREQ-1:0] pend;
    int           gnted;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rndW();
        logic [W-1:0] v = '0;
        for (int i = 0; i < 8; i++) v = W'({v, $urandom()});
        return v;
    endfunction

    task automatic doReset();
        @(negedge iClk);
        iRstn   = 1'b0;
        iReqVld = '1;
        iRdRdy  = 1'b1;
        iFlush  = 1'b0;
        #1;
        chk("rst_gnt",   W'(oReqGnt),    '0);
        chk("rst_we",    W'(oFifoWe),    '0);
        chk("rst_wdata", oFifoWData,     '0);
        chk("rst_re",    W'(oFifoRe),    '0);
        chk("rst_rdvld", W'(oRdVld),     '0);
        chk("rst_level", W'(oLevel),     '0);
        chk("rst_busy",  W'(oBusy),      '0);
        chk("rst_done",  W'(oFlushDone), '0);
        q.delete();
        mPtr   = 0;
        mState = 0;
        @(negedge iClk);
        iRstn   = 1'b1;
        iReqVld = '0;
        iRdRdy  = 1'b0;
    endtask

    task automatic step(input logic [NREQ-1:0] req, input logic rdy, input logic fl, output int gOut);
        int              g;
        int              n;
        int              idx;
        logic [NREQ-1:0] expGnt;
        logic            expRdVld;
        logic            expRe;
        logic [W-1:0]    expWData;
        @(negedge iClk);
        iReqVld = req;
        iRdRdy  = rdy;
        iFlush  = fl;
        for (int i = 0; i < int'(NREQ); i++) begin
            reqData[i] = rndW();
            iReqData[i*W +: W] = reqData[i];
        end
        iFifoRData = (q.size() != 0) ? q[0] : rndW();
        #2;
        n      = q.size();
        g      = -1;
        expGnt = '0;
        if (mState == 0 && n < int'(DEPTH)) begin
            for (int k = 0; k < int'(NREQ); k++) begin
                idx = (mPtr + k) % int'(NREQ);
                if (g < 0 && req[idx]) g = idx;
            end
        end
        if (g >= 0) expGnt[g] = 1'b1;
        expWData = (g >= 0) ? reqData[g] : '0;
        expRdVld = (mState == 0) && (n != 0);
        expRe    = (expRdVld && rdy) || (mState == 1 && n != 0);
        chk("gnt",   W'(oReqGnt),    W'(expGnt));
        chk("we",    W'(oFifoWe),    W'(g >= 0));
        chk("wdata", oFifoWData,     expWData);
        chk("re",    W'(oFifoRe),    W'(expRe));
        chk("rdvld", W'(oRdVld),     W'(expRdVld));
        chk("rddata", oRdData,       iFifoRData);
        chk("level", W'(oLevel),     W'(n));
        chk("busy",  W'(oBusy),      W'(mState != 0));
        chk("done",  W'(oFlushDone), W'(mState == 2));
        if (expRe) void'(q.pop_front());
        if (g >= 0) begin
            q.push_back(reqData[g]);
            mPtr = (g + 1) % int'(NREQ);
        end
        case (mState)
            0: if (fl) mState = 1;
            1: if (n == 0) mState = 2;
            default: mState = 0;
        endcase
        gOut = g;
    endtask

    initial begin
        iRstn      = 1'b0;
        iReqVld    = '0;
        iReqData   = '0;
        iRdRdy     = 1'b0;
        iFlush     = 1'b0;
        iFifoRData = '0;
        mPtr       = 0;
        mState     = 0;
        doReset();

        // Fill with all requesters active: rotating grants until full.
        repeat (10) step(4'b1111, 1'b0, 1'b0, gnted);
        chk("full_level", W'(oLevel), W'(DEPTH));
        // Full plus pop: no grant this cycle, refill next.
        step(4'b0001, 1'b1, 1'b0, gnted);
        step(4'b0001, 1'b0, 1'b0, gnted);
        // Drain to 3, then simultaneous write/read.
        repeat (5) step(4'b0000, 1'b1, 1'b0, gnted);
        repeat (6) step(4'b0100, 1'b1, 1'b0, gnted);
        // Grow to 5 and flush.
        repeat (2) step(4'b0001, 1'b0, 1'b0, gnted);
        step(4'b0000, 1'b0, 1'b1, gnted);
        repeat (8) step(4'b0000, 1'b1, 1'b0, gnted);
        repeat (2) step(4'b0010, 1'b0, 1'b0, gnted);
        // Flush with an empty FIFO.
        repeat (3) step(4'b0000, 1'b1, 1'b0, gnted);
        step(4'b0000, 1'b0, 1'b1, gnted);
        repeat (3) step(4'b0000, 1'b0, 1'b0, gnted);
        // Reset in the middle of a flush at level 3.
        repeat (3) step(4'b1000, 1'b0, 1'b0, gnted);
        step(4'b0000, 1'b0, 1'b1, gnted);
        repeat (2) step(4'b0000, 1'b0, 1'b0, gnted);
        doReset();
        repeat (4) step(4'b1111, 1'b0, 1'b0, gnted);

        // Random traffic; requests are held until granted.
        pend = '0;
        repeat (3000) begin
            pend = pend | (NREQ'($urandom()) & NREQ'($urandom()));
            step(pend, 1'($urandom()), ($urandom() % 40) == 0, gnted);
            if (gnted >= 0) pend[gnted] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
